// File: rtl/dcache_pkg.sv
// Data cache types: FSM state encoding, address field widths and address view.
package dcache_pkg;
  import pipeline::*;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_WRITE,
    S_RESP
  } dcache_state_e;

  // Byte offset width within one XLEN word.
  localparam int BYTE_W = $clog2(XLEN / 8);

  function automatic int word_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines, input int line_words);
    return XLEN - BYTE_W - $clog2(line_words) - $clog2(lines);
  endfunction

  // Field widths of the default geometry (64 lines of 4 words).
  localparam int DEF_LINES      = 64;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_WORD_W     = word_w(DEF_LINE_WORDS);
  localparam int DEF_INDEX_W    = index_w(DEF_LINES);
  localparam int DEF_TAG_W      = tag_w(DEF_LINES, DEF_LINE_WORDS);

  // Address view for the default geometry, most significant field first.
  typedef struct packed {
    logic [DEF_TAG_W-1:0]   tag;
    logic [DEF_INDEX_W-1:0] index;
    logic [DEF_WORD_W-1:0]  word;
    logic [BYTE_W-1:0]      boff;
  } dcache_addr_t;
endpackage

// File: rtl/pipeline_pkg.sv
// Core-wide pipeline constants shared by the load/store path and its caches.
package pipeline;
  localparam int XLEN = 32;
endpackage

// File: rtl/c2c_data.sv
// Request/acknowledge data port between core, caches and memory.
interface c2c_data;
  logic                         re;
  logic                         we;
  logic [pipeline::XLEN/8-1:0]  sel;
  logic [pipeline::XLEN-1:0]    addr;
  logic [pipeline::XLEN-1:0]    data_w;
  logic                         ack;
  logic [pipeline::XLEN-1:0]    data_r;

  modport master (output re, we, sel, addr, data_w, input ack, data_r);
  modport slave  (input re, we, sel, addr, data_w, output ack, data_r);
endinterface

// File: rtl/dcache_byte_merge.sv
// Byte-granular merge of a store into an existing word.
module dcache_byte_merge
  import pipeline::*;
(
  input  logic [XLEN-1:0]   old_word,
  input  logic [XLEN-1:0]   new_word,
  input  logic [XLEN/8-1:0] sel,
  output logic [XLEN-1:0]   merged
);

  // Take each byte from the new word where its select bit is set.
  always_comb begin
    merged = old_word;
    for (int b = 0; b < XLEN / 8; b++) begin
      if (sel[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
  end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Read misses refill the whole line word by word; stores always go to memory
// and update the cached copy only when the line is present.
module dcache_wt
  import pipeline::*;
  import dcache_pkg::*;
#(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  c2c_data.slave   core,
  c2c_data.master  mem,
  input  logic     inv
);

  localparam int WORD_W  = word_w(LINE_WORDS);
  localparam int INDEX_W = index_w(LINES);
  localparam int TAG_W   = tag_w(LINES, LINE_WORDS);
  localparam int WORD_LO = BYTE_W;
  localparam int IDX_LO  = BYTE_W + WORD_W;
  localparam int TAG_LO  = IDX_LO + INDEX_W;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

  dcache_state_e     state;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [XLEN-1:0]   data_arr [LINES*LINE_WORDS];
  logic [WORD_W-1:0] cnt;
  logic [WORD_W-1:0] cnt_nxt;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [WORD_W-1:0]  req_word;
  logic               hit;
  logic [XLEN-1:0]    cached_word;
  logic [XLEN-1:0]    merged_word;

  assign req_tag     = core.addr[XLEN-1:TAG_LO];
  assign req_idx     = core.addr[TAG_LO-1:IDX_LO];
  assign req_word    = core.addr[IDX_LO-1:WORD_LO];
  assign hit         = valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign cached_word = data_arr[{req_idx, req_word}];
  // Counter deliberately wraps; the last word is detected by comparison.
  assign cnt_nxt     = cnt + WORD_W'(1);

  dcache_byte_merge u_merge (
    .old_word (cached_word),
    .new_word (core.data_w),
    .sel      (core.sel),
    .merged   (merged_word)
  );

  // Controller: sequences hits, refills and write-throughs with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      valid       <= '0;
      cnt         <= '0;
      core.ack    <= 1'b0;
      core.data_r <= '0;
      mem.re      <= 1'b0;
      mem.we      <= 1'b0;
      mem.sel     <= '0;
      mem.addr    <= '0;
      mem.data_w  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (inv) begin
            // The held request is picked up on the next cycle.
            valid <= '0;
          end else if (core.re) begin
            if (hit) begin
              core.data_r <= cached_word;
              core.ack    <= 1'b1;
              state       <= S_RESP;
            end else begin
              valid[req_idx] <= 1'b0;
              cnt            <= '0;
              mem.re         <= 1'b1;
              mem.sel        <= '1;
              mem.addr       <= {req_tag, req_idx, {WORD_W{1'b0}}, {BYTE_W{1'b0}}};
              state          <= S_REFILL;
            end
          end else if (core.we) begin
            mem.we     <= 1'b1;
            mem.addr   <= core.addr;
            mem.sel    <= core.sel;
            mem.data_w <= core.data_w;
            state      <= S_WRITE;
          end
        end
        S_REFILL: begin
          if (mem.ack) begin
            if (cnt == req_word) core.data_r <= mem.data_r;
            cnt      <= cnt_nxt;
            mem.addr <= {req_tag, req_idx, cnt_nxt, {BYTE_W{1'b0}}};
            if (cnt == LAST_WORD) begin
              valid[req_idx] <= 1'b1;
              mem.re         <= 1'b0;
              core.ack       <= 1'b1;
              state          <= S_RESP;
            end
          end
        end
        S_WRITE: begin
          if (mem.ack) begin
            mem.we   <= 1'b0;
            core.ack <= 1'b1;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          core.ack <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Storage arrays: refill words, tag on the final word, merged store on a write hit.
  always_ff @(posedge clk) begin
    if (state == S_REFILL && mem.ack) begin
      data_arr[{req_idx, cnt}] <= mem.data_r;
      if (cnt == LAST_WORD) tag_arr[req_idx] <= req_tag;
    end
    if (state == S_WRITE && mem.ack && hit) begin
      data_arr[{req_idx, req_word}] <= merged_word;
    end
  end

endmodule

// File: tb/tb_dcache_wt.sv
// Self-checking bench for dcache_wt: directed scenarios followed by random
// traffic, all checked against a line-level cache model and a memory that
// returns addr ^ 0xA5A5_0000.
module tb_dcache_wt;
  import pipeline::*;
  import dcache_pkg::*;

  localparam int LINES = 64;
  localparam int LW    = 4;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst_n;
  logic inv;

  always #5 clk = ~clk;

  c2c_data core_if ();
  c2c_data mem_if ();

  dcache_wt #(.LINES(LINES), .LINE_WORDS(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .core  (core_if),
    .mem   (mem_if),
    .inv   (inv)
  );

  // Memory: acks every cycle after the first cycle of a request.
  logic pend;
  always_ff @(posedge clk) pend <= mem_if.re | mem_if.we;
  always_comb begin
    mem_if.ack    = pend & (mem_if.re | mem_if.we);
    mem_if.data_r = mem_if.addr ^ KEY;
  end

  // Log of memory transactions, one entry per ack.
  logic [31:0] rd_q [$];
  logic [31:0] wa_q [$];
  logic [31:0] wd_q [$];
  logic [3:0]  ws_q [$];
  int          bad_sel = 0;
  always @(posedge clk) begin
    if (mem_if.ack && mem_if.re) begin
      rd_q.push_back(mem_if.addr);
      if (mem_if.sel != 4'hF) bad_sel <= bad_sel + 1;
    end
    if (mem_if.ack && mem_if.we) begin
      wa_q.push_back(mem_if.addr);
      wd_q.push_back(mem_if.data_w);
      ws_q.push_back(mem_if.sel);
    end
  end

  // Reference cache model.
  bit          m_valid [LINES];
  logic [31:0] m_tag   [LINES];
  logic [31:0] m_data  [LINES][LW];
  logic [31:0] m_last;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / (4 * LW)) % LINES);
  endfunction
  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % LW);
  endfunction
  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / (4 * LW * LINES);
  endfunction

  function automatic logic [31:0] mk_addr(input int t, input int i, input int w);
    dcache_addr_t a;
    a.tag   = DEF_TAG_W'(t);
    a.index = DEF_INDEX_W'(i);
    a.word  = DEF_WORD_W'(w);
    a.boff  = '0;
    return a;
  endfunction

  task automatic model_clear();
    for (int j = 0; j < LINES; j++) m_valid[j] = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_core_ack"},  32'(core_if.ack), 32'd0);
    chk({pfx, "_core_data"}, core_if.data_r,   32'd0);
    chk({pfx, "_mem_re"},    32'(mem_if.re),   32'd0);
    chk({pfx, "_mem_we"},    32'(mem_if.we),   32'd0);
    chk({pfx, "_mem_sel"},   32'(mem_if.sel),  32'd0);
    chk({pfx, "_mem_addr"},  mem_if.addr,      32'd0);
    chk({pfx, "_mem_dataw"}, mem_if.data_w,    32'd0);
  endtask

  // Waits for core ack; returns cycles counted from the request.
  task automatic wait_ack(output int k, output bit got);
    k   = 0;
    got = 1'b0;
    while (k < 50 && !got) begin
      @(negedge clk);
      k++;
      inv = 1'b0;
      if (core_if.ack) got = 1'b1;
    end
  endtask

  task automatic do_read(input logic [31:0] a, input bit with_inv);
    int          i;
    int          w;
    logic [31:0] t;
    logic [31:0] base;
    logic [31:0] exp_d;
    bit          hit;
    int          exp_lat;
    int          k;
    bit          got;
    i    = idx_of(a);
    w    = word_of(a);
    t    = tag_of(a);
    base = a - (a % (4 * LW));
    if (with_inv) model_clear();
    hit = m_valid[i] && (m_tag[i] == t);
    if (!hit) begin
      for (int j = 0; j < LW; j++) m_data[i][j] = (base + 32'(4 * j)) ^ KEY;
      m_valid[i] = 1'b1;
      m_tag[i]   = t;
    end
    exp_d   = m_data[i][w];
    m_last  = exp_d;
    exp_lat = (hit ? 1 : LW + 2) + (with_inv ? 1 : 0);
    rd_q.delete();
    wa_q.delete();
    core_if.addr = a;
    core_if.re   = 1'b1;
    inv          = with_inv;
    wait_ack(k, got);
    core_if.re = 1'b0;
    chk("rd_ack_seen", 32'(got), 32'd1);
    chk("rd_latency", 32'(k), 32'(exp_lat));
    chk("rd_data", core_if.data_r, exp_d);
    chk("rd_mem_reads", 32'(rd_q.size()), hit ? 32'd0 : 32'(LW));
    for (int j = 0; j < rd_q.size() && j < LW; j++)
      chk("rd_mem_addr", rd_q[j], base + 32'(4 * j));
    chk("rd_mem_writes", 32'(wa_q.size()), 32'd0);
    @(negedge clk);
    chk("rd_ack_pulse", 32'(core_if.ack), 32'd0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] sel, input logic [31:0] d);
    int          i;
    int          w;
    int          k;
    bit          got;
    i = idx_of(a);
    w = word_of(a);
    if (m_valid[i] && m_tag[i] == tag_of(a)) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) m_data[i][w][8*b +: 8] = d[8*b +: 8];
    end
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
    ws_q.delete();
    core_if.addr   = a;
    core_if.sel    = sel;
    core_if.data_w = d;
    core_if.we     = 1'b1;
    wait_ack(k, got);
    core_if.we = 1'b0;
    chk("wr_ack_seen", 32'(got), 32'd1);
    chk("wr_latency", 32'(k), 32'd3);
    chk("wr_data_r_held", core_if.data_r, m_last);
    chk("wr_mem_writes", 32'(wa_q.size()), 32'd1);
    chk("wr_mem_reads", 32'(rd_q.size()), 32'd0);
    if (wa_q.size() > 0) begin
      chk("wr_mem_addr", wa_q[0], a);
      chk("wr_mem_sel", 32'(ws_q[0]), 32'(sel));
      chk("wr_mem_data", wd_q[0], d);
    end
    @(negedge clk);
    chk("wr_ack_pulse", 32'(core_if.ack), 32'd0);
  endtask

  initial begin
    int k;
    rst_n          = 1'b0;
    inv            = 1'b0;
    core_if.re     = 1'b0;
    core_if.we     = 1'b0;
    core_if.sel    = '0;
    core_if.addr   = '0;
    core_if.data_w = '0;
    model_clear();
    m_last = '0;

    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Cold miss, then hit in the same line.
    do_read(32'h0000_1004, 1'b0);
    do_read(32'h0000_1008, 1'b0);
    // Write hit merges one byte.
    do_write(32'h0000_1004, 4'b0010, 32'h0000_BB00);
    do_read(32'h0000_1004, 1'b0);
    // Write miss does not allocate.
    do_write(32'h0000_2000, 4'b1111, 32'h1234_5678);
    do_read(32'h0000_2000, 1'b0);
    // Conflicting tags on index 0.
    do_read(32'h0000_1004, 1'b0);
    do_read(32'h0000_1404, 1'b0);
    do_read(32'h0000_1004, 1'b0);
    // Invalidate coinciding with a read of a cached line.
    do_read(32'h0000_1008, 1'b0);
    do_read(32'h0000_1008, 1'b1);

    // Reset in the middle of a refill.
    inv = 1'b1;
    @(negedge clk);
    inv = 1'b0;
    model_clear();
    rd_q.delete();
    core_if.addr = 32'h0000_1004;
    core_if.re   = 1'b1;
    k = 0;
    while (k < 50 && rd_q.size() < 2) begin
      @(negedge clk);
      k++;
    end
    chk("rst_refill_acks", 32'(rd_q.size()), 32'd2);
    rst_n      = 1'b0;
    core_if.re = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    m_last = '0;
    @(negedge clk);
    do_read(32'h0000_1004, 1'b0);

    // Random traffic over a few tags and indices.
    for (int n = 0; n < 150; n++) begin
      int unsigned op;
      logic [31:0] a;
      a  = mk_addr(32 + int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, LW - 1)));
      op = $urandom_range(0, 99);
      if (op < 55)      do_read(a, 1'b0);
      else if (op < 93) do_write(a, 4'($urandom), $urandom);
      else              do_read(a, 1'b1);
    end

    chk("mem_read_sel", 32'(bad_sel), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
